// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the ID-stage hazard stall
//                unit. It defines the stall FSM state encoding and the
//                hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE  = 2'b00,
        HZ_STALL = 2'b01
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational hazard classifier for the instruction in ID.
//                h2 : the branch needs the result of a load that is in EX
//                     (two extra stall cycles).
//                h1 : load-use, a branch needing an ALU result from EX, or a
//                     branch needing a load result from MEM (one extra cycle).
//                The two outputs are independent; the FSM gives h2 priority.
//  Ports       : addrReg1/2, useReg1/2 - ID source operands and their use
//                branch                - ID instruction compares in ID
//                addrWriteEx/Mem       - rd of the EX / MEM instructions
//                regWriteEx/Mem        - EX / MEM instruction writes rd
//                memReadEx/Mem         - EX / MEM instruction is a load
//                h1, h2                - hazard class flags
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] addrReg1,
    input  logic [4:0] addrReg2,
    input  logic       useReg1,
    input  logic       useReg2,
    input  logic       branch,
    input  logic [4:0] addrWriteEx,
    input  logic       regWriteEx,
    input  logic       memReadEx,
    input  logic [4:0] addrWriteMem,
    input  logic       regWriteMem,
    input  logic       memReadMem,
    output logic       h1,
    output logic       h2
);

    logic w_match_ex1;
    logic w_match_ex2;
    logic w_match_mem1;
    logic w_match_mem2;
    logic w_match_ex;
    logic w_match_mem;

    // x0 is hard-wired to zero, so a write to it never produces a dependency.
    assign w_match_ex1  = useReg1 & regWriteEx  & (addrReg1 == addrWriteEx)  & (addrReg1 != REG_ZERO);
    assign w_match_ex2  = useReg2 & regWriteEx  & (addrReg2 == addrWriteEx)  & (addrReg2 != REG_ZERO);
    assign w_match_mem1 = useReg1 & regWriteMem & (addrReg1 == addrWriteMem) & (addrReg1 != REG_ZERO);
    assign w_match_mem2 = useReg2 & regWriteMem & (addrReg2 == addrWriteMem) & (addrReg2 != REG_ZERO);

    assign w_match_ex  = w_match_ex1  | w_match_ex2;
    assign w_match_mem = w_match_mem1 | w_match_mem2;

    assign h2 = branch & memReadEx & w_match_ex;

    assign h1 = (~branch & memReadEx  & w_match_ex)
              | ( branch & ~memReadEx & w_match_ex)
              | ( branch & memReadMem & w_match_mem);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : ID-stage stall/flush controller. It holds the PC and IF/ID
//                and bubbles ID/EX while an operand of the ID instruction
//                cannot be forwarded yet, flushes IF/ID on a taken branch,
//                and keeps saturating stall/flush event counters.
//  Ports       : clk, reset_n         - clock, async active-low reset
//                addrReg*/useReg*     - ID source operands
//                branch, branchTaken  - ID branch and its resolution
//                *Ex / *Mem           - EX / MEM destination info
//                clearCounters        - synchronous counter clear
//                stallPC, stallIFID,
//                bubbleIDEX           - stall controls (always identical)
//                flushIFID            - IF/ID flush on taken branch
//                hazardState          - FSM state for debug
//                stallCount/flushCount- saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       addrReg1,
    input  logic [4:0]       addrReg2,
    input  logic             useReg1,
    input  logic             useReg2,
    input  logic             branch,
    input  logic             branchTaken,
    input  logic [4:0]       addrWriteEx,
    input  logic             regWriteEx,
    input  logic             memReadEx,
    input  logic [4:0]       addrWriteMem,
    input  logic             regWriteMem,
    input  logic             memReadMem,
    input  logic             clearCounters,
    output logic             stallPC,
    output logic             stallIFID,
    output logic             bubbleIDEX,
    output logic             flushIFID,
    output logic [1:0]       hazardState,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    hz_state_t        r_state;
    logic             r_remain;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_h1;
    logic w_h2;
    logic w_idle;
    logic w_stall;
    logic w_flush;

    hazard_detect u_detect (
        .addrReg1     (addrReg1),
        .addrReg2     (addrReg2),
        .useReg1      (useReg1),
        .useReg2      (useReg2),
        .branch       (branch),
        .addrWriteEx  (addrWriteEx),
        .regWriteEx   (regWriteEx),
        .memReadEx    (memReadEx),
        .addrWriteMem (addrWriteMem),
        .regWriteMem  (regWriteMem),
        .memReadMem   (memReadMem),
        .h1           (w_h1),
        .h2           (w_h2)
    );

    assign w_idle = (r_state == HZ_IDLE);

    // Stall is asserted in the detect cycle itself (zero latency) and for
    // every cycle spent in STALL. Gating with reset_n keeps the pipeline
    // controls quiet while reset is held, whatever the inputs are doing.
    assign w_stall = reset_n & ((w_idle & (w_h1 | w_h2)) | (r_state == HZ_STALL));

    // A taken branch seen during a stall is ignored; the branch unit will
    // re-assert it once the operands are available.
    assign w_flush = reset_n & branchTaken & ~w_stall & w_idle;

    assign stallPC     = w_stall;
    assign stallIFID   = w_stall;
    assign bubbleIDEX  = w_stall;
    assign flushIFID   = w_flush;
    assign hazardState = r_state;
    assign stallCount  = r_stall_cnt;
    assign flushCount  = r_flush_cnt;

    // remain counts stall cycles still owed after the current STALL cycle:
    // h2 owes two beyond the detect cycle, h1 owes one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= HZ_IDLE;
            r_remain <= 1'b0;
        end else begin
            case (r_state)
                HZ_IDLE: begin
                    if (w_h2) begin
                        r_state  <= HZ_STALL;
                        r_remain <= 1'b1;
                    end else if (w_h1) begin
                        r_state  <= HZ_STALL;
                        r_remain <= 1'b0;
                    end
                end
                HZ_STALL: begin
                    if (r_remain) begin
                        r_remain <= 1'b0;
                    end else begin
                        r_state <= HZ_IDLE;
                    end
                end
                default: begin
                    r_state  <= HZ_IDLE;
                    r_remain <= 1'b0;
                end
            endcase
        end
    end

    // Counters saturate rather than wrap; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clearCounters) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Self-checking bench for hazard_stall_unit. Directed
//                scenarios followed by randomized traffic, all compared
//                against a cycle-count reference model (outstanding stall
//                cycles as an integer, counters as saturating integers).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       addrReg1, addrReg2, addrWriteEx, addrWriteMem;
    logic             useReg1, useReg2, branch, branchTaken;
    logic             regWriteEx, memReadEx, regWriteMem, memReadMem;
    logic             clearCounters;
    logic             stallPC, stallIFID, bubbleIDEX, flushIFID;
    logic [1:0]       hazardState;
    logic [CNT_W-1:0] stallCount, flushCount;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int m_left;       // stall cycles still owed after the current one
    int m_stall_cnt;
    int m_flush_cnt;

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addrReg1      (addrReg1),
        .addrReg2      (addrReg2),
        .useReg1       (useReg1),
        .useReg2       (useReg2),
        .branch        (branch),
        .branchTaken   (branchTaken),
        .addrWriteEx   (addrWriteEx),
        .regWriteEx    (regWriteEx),
        .memReadEx     (memReadEx),
        .addrWriteMem  (addrWriteMem),
        .regWriteMem   (regWriteMem),
        .memReadMem    (memReadMem),
        .clearCounters (clearCounters),
        .stallPC       (stallPC),
        .stallIFID     (stallIFID),
        .bubbleIDEX    (bubbleIDEX),
        .flushIFID     (flushIFID),
        .hazardState   (hazardState),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dep(input bit use_r, input bit wr, input logic [4:0] a, input logic [4:0] w);
        return use_r && wr && (a == w) && (a != 5'd0);
    endfunction

    task automatic idle_inputs();
        addrReg1 = 5'd0; addrReg2 = 5'd0; useReg1 = 1'b0; useReg2 = 1'b0;
        branch = 1'b0; branchTaken = 1'b0;
        addrWriteEx = 5'd0; regWriteEx = 1'b0; memReadEx = 1'b0;
        addrWriteMem = 5'd0; regWriteMem = 1'b0; memReadMem = 1'b0;
        clearCounters = 1'b0;
    endtask

    // Called just after the negedge with inputs already applied: checks the
    // current-cycle outputs, then advances the model across the next posedge.
    task automatic tick();
        bit dep_ex, dep_mem, h1, h2, exp_stall, exp_flush;
        dep_ex  = dep(useReg1, regWriteEx, addrReg1, addrWriteEx)
               || dep(useReg2, regWriteEx, addrReg2, addrWriteEx);
        dep_mem = dep(useReg1, regWriteMem, addrReg1, addrWriteMem)
               || dep(useReg2, regWriteMem, addrReg2, addrWriteMem);
        h2 = branch && memReadEx && dep_ex;
        h1 = (!branch && memReadEx && dep_ex) || (branch && !memReadEx && dep_ex)
          || (branch && memReadMem && dep_mem);
        exp_stall = (m_left > 0) || h1 || h2;
        exp_flush = branchTaken && !exp_stall && (m_left == 0);
        #1;
        chk("stallPC",     {31'd0, stallPC},     {31'd0, exp_stall});
        chk("stallIFID",   {31'd0, stallIFID},   {31'd0, exp_stall});
        chk("bubbleIDEX",  {31'd0, bubbleIDEX},  {31'd0, exp_stall});
        chk("flushIFID",   {31'd0, flushIFID},   {31'd0, exp_flush});
        chk("hazardState", {30'd0, hazardState}, (m_left > 0) ? 32'd1 : 32'd0);
        chk("stallCount",  {{(32-CNT_W){1'b0}}, stallCount}, m_stall_cnt);
        chk("flushCount",  {{(32-CNT_W){1'b0}}, flushCount}, m_flush_cnt);
        @(posedge clk);
        if (clearCounters) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (exp_stall && m_stall_cnt < CNT_SAT) m_stall_cnt++;
            if (exp_flush && m_flush_cnt < CNT_SAT) m_flush_cnt++;
        end
        if (m_left > 0)  m_left--;
        else if (h2)     m_left = 2;
        else if (h1)     m_left = 1;
    endtask

    task automatic model_reset();
        m_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, {29'd0, stallPC, stallIFID, bubbleIDEX}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flushIFID}, 32'd0);
        chk({tag, "_state"}, {30'd0, hazardState}, 32'd0);
        chk({tag, "_cnts"},  {{(32-2*CNT_W){1'b0}}, stallCount, flushCount}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        // A hazard present during reset must not leak onto the outputs.
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd5;
        addrReg1 = 5'd5; useReg1 = 1'b1;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        tick();

        // Load-use: lw x5 in EX, add reading x5 in ID -> 2 stall cycles.
        @(negedge clk);
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd5;
        addrReg1 = 5'd5; useReg1 = 1'b1;
        tick();
        @(negedge clk); tick();
        @(negedge clk); idle_inputs(); tick();
        chk("loaduse_cnt", {{(32-CNT_W){1'b0}}, stallCount}, 32'd2);

        // Branch after ALU with branchTaken during the stall (masked).
        @(negedge clk);
        regWriteEx = 1'b1; addrWriteEx = 5'd7;
        addrReg2 = 5'd7; useReg2 = 1'b1; branch = 1'b1; branchTaken = 1'b1;
        tick();
        @(negedge clk); tick();
        @(negedge clk); idle_inputs(); tick();

        // Branch after load -> 3 stall cycles, then a taken branch flushes.
        @(negedge clk);
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd3;
        addrReg1 = 5'd3; useReg1 = 1'b1; branch = 1'b1;
        tick();
        @(negedge clk); tick();
        @(negedge clk); tick();
        @(negedge clk); idle_inputs(); branch = 1'b1; branchTaken = 1'b1; tick();
        @(negedge clk); idle_inputs(); tick();
        chk("brload_flush", {{(32-CNT_W){1'b0}}, flushCount}, 32'd1);
        chk("brload_stall", {{(32-CNT_W){1'b0}}, stallCount}, 32'd7);

        // x0 never hazards; an unused operand never hazards.
        @(negedge clk);
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd0;
        addrReg1 = 5'd0; useReg1 = 1'b1;
        tick();
        @(negedge clk);
        idle_inputs();
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd4;
        addrReg2 = 5'd4; useReg2 = 1'b0;
        tick();

        // Reset in the 2nd stall cycle of an H2 stall.
        @(negedge clk);
        idle_inputs();
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd9;
        addrReg1 = 5'd9; useReg1 = 1'b1; branch = 1'b1;
        tick();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        tick();

        // Saturation: a held load-use keeps stalling back-to-back.
        @(negedge clk);
        memReadEx = 1'b1; regWriteEx = 1'b1; addrWriteEx = 5'd6;
        addrReg2 = 5'd6; useReg2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
        end
        chk("sat_cnt", {{(32-CNT_W){1'b0}}, stallCount}, CNT_SAT);
        clearCounters = 1'b1;   // clear while stalling overrides increment
        tick();
        @(negedge clk);
        clearCounters = 1'b0;
        idle_inputs();
        #1;
        chk("clr_cnt", {{(32-CNT_W){1'b0}}, stallCount}, 32'd0);
        tick();

        // Randomized traffic on a small register set to make hazards common.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            addrReg1      = 5'($urandom_range(0, 3));
            addrReg2      = 5'($urandom_range(0, 3));
            addrWriteEx   = 5'($urandom_range(0, 3));
            addrWriteMem  = 5'($urandom_range(0, 3));
            useReg1       = 1'($urandom);
            useReg2       = 1'($urandom);
            branch        = 1'($urandom);
            branchTaken   = 1'($urandom);
            regWriteEx    = 1'($urandom);
            memReadEx     = 1'($urandom);
            regWriteMem   = 1'($urandom);
            memReadMem    = 1'($urandom);
            clearCounters = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_hazard_stall_unit
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage stall/flush controller placed directly upstream of the branch forwarding mux-select logic.
- Decides when the instruction in ID must be held because a needed operand cannot be forwarded yet: load-use, a branch depending on an EX result, or a branch depending on a load.
- Drives PC/IF-ID hold, ID/EX bubble insertion and IF/ID flush on taken branches.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of the stallCount and flushCount counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addrReg1  in  5  rs1 of the instruction in ID.
- addrReg2  in  5  rs2 of the instruction in ID.
- useReg1  in  1  ID instruction reads rs1.
- useReg2  in  1  ID instruction reads rs2.
- branch  in  1  ID instruction is a branch or JALR, with operands compared in ID.
- branchTaken  in  1  branch in ID resolved taken this cycle.
- addrWriteEx  in  5  rd of the instruction in EX.
- regWriteEx  in  1  EX instruction writes rd.
- memReadEx  in  1  EX instruction is a load.
- addrWriteMem  in  5  rd of the instruction in MEM.
- regWriteMem  in  1  MEM instruction writes rd.
- memReadMem  in  1  MEM instruction is a load.
- clearCounters  in  1  synchronous clear of both counters.
- stallPC  out  1  hold the PC.
- stallIFID  out  1  hold the IF/ID register.
- bubbleIDEX  out  1  load a NOP into ID/EX.
- flushIFID  out  1  zero the IF/ID register.
- hazardState  out  2  current FSM state, for debug.
- stallCount  out  CNT_W  cycles with stallIFID=1.
- flushCount  out  CNT_W  cycles with flushIFID=1.

Behaviour:
- Operand match rule: matchEx1 = useReg1 & regWriteEx & (addrReg1 == addrWriteEx) & (addrReg1 != 0). matchEx2, matchMem1 and matchMem2 follow the same rule. Register x0 never causes a hazard.
- Hazard classes, evaluated only in state IDLE:
  - H2 (2 stall cycles): branch & memReadEx & (matchEx1 | matchEx2).
  - H1 (1 stall cycle), any of:
    - !branch & memReadEx & matchEx (load-use);
    - branch & !memReadEx & matchEx (ALU result needed in ID);
    - branch & memReadMem & matchMem (load data reaches WB next cycle).
  - H2 has priority over H1.
- FSM states: IDLE=2'b00, STALL=2'b01. A 1-bit register, remain, tracks outstanding stall cycles.
  - IDLE, H2 detected: stall=1 this cycle, go to STALL, remain<=1.
  - IDLE, H1 detected (no H2): stall=1, go to STALL, remain<=0.
  - IDLE, no hazard: stall=0, stay in IDLE.
  - STALL with remain=1: stall=1, remain<=0, stay in STALL.
  - STALL with remain=0: stall=1, go to IDLE. Detection resumes next cycle.
  - Result: H2 gives exactly 3 stall cycles (detect cycle + 2). H1 gives exactly 2 stall cycles (detect cycle + 1).
- While stall=1: stallPC = stallIFID = bubbleIDEX = 1. All three are identical every cycle.
- flushIFID = branchTaken & !stall & (state == IDLE). A branchTaken asserted during a stall is masked; the branch unit re-asserts it after operands resolve.
- Stall and flush outputs are combinational from state and inputs, with zero latency.
- Counters:
  - stallCount += 1 on every clock with stallIFID=1; flushCount += 1 on every clock with flushIFID=1.
  - Both saturate at all-ones and do not wrap.
  - clearCounters=1 sets both to 0 on the next edge and overrides an increment in the same cycle.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, remain=0, stallCount=0, flushCount=0.
  - stallPC, stallIFID, bubbleIDEX and flushIFID are forced to 0 while reset_n=0.
  - hazardState reads 2'b00.
  - A reset in the middle of a stall abandons it. After release, detection restarts from IDLE.
- Simultaneous H1 and H2 on different operands: H2 wins (3 cycles), with no additional cycles.

Decomposition:
- Shared package hazard_pkg:
  - typedef enum logic [1:0] {HZ_IDLE=2'b00, HZ_STALL=2'b01} hz_state_t;
  - localparam REG_ZERO=5'd0.
- One sub-module, hazard_detect: purely combinational, takes the addr/use/write/read inputs and outputs h1 and h2. It is instantiated once. The top module holds the FSM, the remain register, output gating and the counters.

Test Plan:
- Load-use: EX lw x5 (memReadEx=1, regWriteEx=1, addrWriteEx=5); ID add reading addrReg1=5, useReg1=1, branch=0 -> stall=1 for exactly 2 cycles; hazardState 00->01->00; stallCount=2.
- Branch after ALU: EX add x7; ID beq with addrReg2=7, branch=1 -> 2 stall cycles, no flush; branchTaken=1 during the stall -> flushIFID=0.
- Branch after load: EX lw x3; ID bne with addrReg1=3 -> exactly 3 stall cycles; then branchTaken=1 in IDLE -> flushIFID=1 for 1 cycle; flushCount=1.
- x0 and no-use: EX lw x0 with ID addrReg1=0 -> no stall; EX lw x4 with ID addrReg2=4 but useReg2=0 -> no stall.
- Reset mid-stall: start H2, pull reset_n low in the 2nd stall cycle -> outputs go to 0 immediately, counters 0, state 00; release with no hazard -> no stall.
- Counters: preload stallCount to all-ones with a forced stall -> it holds at all-ones; clearCounters=1 with stall=1 -> count=0 next edge.
